// File: rtl/offset_extend_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : offset_extend_arbiter
// Purpose  : Round-robin shared offset sign/zero extender for two requesters,
//            registered result under valid/ready. Optional: OFFSET_ARB_ZEXT_EN.
// Revision : 1.0  initial release
// ============================================================================
module offset_extend_arbiter #(
    parameter int IN_WIDTH  = 4,
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req0,
    input  logic [IN_WIDTH-1:0]  offset0,
    output logic                 ack0,
    input  logic                 req1,
    input  logic [IN_WIDTH-1:0]  offset1,
    output logic                 ack1,
`ifdef OFFSET_ARB_ZEXT_EN
    input  logic                 zext0,
    input  logic                 zext1,
`endif
    output logic [OUT_WIDTH-1:0] result,
    output logic                 result_id,
    output logic                 result_valid,
    input  logic                 result_ready
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXT  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           r_state;
    logic [IN_WIDTH-1:0]  r_op;
    logic                 r_sel;
    logic                 r_last;
    logic                 r_zext;

    logic                 w_any;
    logic                 w_pick;
    logic [IN_WIDTH-1:0]  w_offset;
    logic                 w_zext_in;
    logic                 w_fill;
    logic [OUT_WIDTH-1:0] w_ext;

    assign w_any    = req0 | req1;
    // On a tie the port that did not win last time gets the grant.
    assign w_pick   = (req0 & req1) ? ~r_last : req1;
    assign w_offset = w_pick ? offset1 : offset0;

`ifdef OFFSET_ARB_ZEXT_EN
    assign w_zext_in = w_pick ? zext1 : zext0;
`else
    assign w_zext_in = 1'b0;
`endif

    assign w_fill = r_op[IN_WIDTH-1] & ~r_zext;

    generate
        if (OUT_WIDTH > IN_WIDTH) begin : g_ext_wide
            assign w_ext = {{(OUT_WIDTH-IN_WIDTH){w_fill}}, r_op};
        end else begin : g_ext_same
            assign w_ext = r_op;
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_op         <= '0;
            r_sel        <= 1'b0;
            r_last       <= 1'b1;
            r_zext       <= 1'b0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            result       <= '0;
            result_id    <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (r_state)
                S_EXT: begin
                    result       <= w_ext;
                    result_id    <= r_sel;
                    result_valid <= 1'b1;
                    r_state      <= S_DONE;
                end
                default: begin
                    // IDLE, DONE with the result accepted, or an illegal code.
                    if (!((r_state == S_DONE) && !result_ready)) begin
                        result_valid <= 1'b0;
                        if (w_any) begin
                            r_op    <= w_offset;
                            r_zext  <= w_zext_in;
                            r_sel   <= w_pick;
                            r_last  <= w_pick;
                            ack0    <= ~w_pick;
                            ack1    <= w_pick;
                            r_state <= S_EXT;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_offset_extend_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_offset_extend_arbiter
// Purpose  : Vector table, directed corner sequences and random transaction
//            scoreboard for offset_extend_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_offset_extend_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [3:0]  offset0, offset1;
    logic        ack0, ack1;
    logic        zext0, zext1;
    logic [15:0] result;
    logic        result_id, result_valid, result_ready;

    int checks   = 0;
    int failures = 0;

    offset_extend_arbiter #(.IN_WIDTH(4), .OUT_WIDTH(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .req0         (req0),
        .offset0      (offset0),
        .ack0         (ack0),
        .req1         (req1),
        .offset1      (offset1),
        .ack1         (ack1),
`ifdef OFFSET_ARB_ZEXT_EN
        .zext0        (zext0),
        .zext1        (zext1),
`endif
        .result       (result),
        .result_id    (result_id),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        r0;
        logic [3:0]  o0;
        logic        r1;
        logic [3:0]  o1;
        logic        id;
        logic [15:0] res;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Value of the offset as a signed (or unsigned) integer, truncated to 16 bits.
    function automatic logic [15:0] ext_ref(input logic [3:0] o, input logic z);
        int v;
        v = int'(o);
        if (!z && o >= 4'd8) v = v - 16;
        return 16'(v);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; result_ready = 1'b0;
        zext0 = 1'b0; zext1 = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          inflight, exp_valid, exp_id, last_m, w;
        bit          e_a0, e_a1;
        logic [15:0] exp_res;
        logic        d_r0, d_r1, d_rdy, d_z0, d_z1;
        logic [3:0]  d_o0, d_o1;

        vecs[0] = '{1'b1, 4'b0101, 1'b0, 4'h0,    1'b0, 16'h0005};
        vecs[1] = '{1'b0, 4'h0,    1'b1, 4'b1010, 1'b1, 16'hFFFA};
        vecs[2] = '{1'b1, 4'h3,    1'b1, 4'h8,    1'b0, 16'h0003};
        vecs[3] = '{1'b1, 4'h3,    1'b1, 4'h8,    1'b1, 16'hFFF8};
        vecs[4] = '{1'b0, 4'h0,    1'b1, 4'b0111, 1'b1, 16'h0007};
        vecs[5] = '{1'b1, 4'hF,    1'b1, 4'h0,    1'b0, 16'hFFFF};
        vecs[6] = '{1'b1, 4'h8,    1'b0, 4'h0,    1'b0, 16'hFFF8};
        vecs[7] = '{1'b1, 4'h0,    1'b1, 4'h0,    1'b1, 16'h0000};

        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; offset0 = '0; offset1 = '0;
        result_ready = 1'b0; zext0 = 1'b0; zext1 = 1'b0;
        step();
        chk("reset_result", result, 0);
        chk("reset_id", result_id, 0);
        chk("reset_valid", result_valid, 0);
        chk("reset_ack0", ack0, 0);
        chk("reset_ack1", ack1, 0);
        step();
        reset = 1'b0;

        // Single transactions from idle; the round-robin pointer carries across rows.
        result_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req0 = vecs[i].r0; offset0 = vecs[i].o0;
            req1 = vecs[i].r1; offset1 = vecs[i].o1;
            step();
            chk($sformatf("vec%0d_ack0", i), ack0, !vecs[i].id);
            chk($sformatf("vec%0d_ack1", i), ack1, vecs[i].id);
            chk($sformatf("vec%0d_valid_early", i), result_valid, 0);
            req0 = 1'b0; req1 = 1'b0;
            step();
            chk($sformatf("vec%0d_valid", i), result_valid, 1);
            chk($sformatf("vec%0d_result", i), result, vecs[i].res);
            chk($sformatf("vec%0d_id", i), result_id, vecs[i].id);
            chk($sformatf("vec%0d_noack", i), {ack0, ack1}, 0);
            step();
            chk($sformatf("vec%0d_valid_drop", i), result_valid, 0);
        end

        // Back-to-back tie: grants alternate starting at port 0, one result per 2 cycles.
        apply_reset();
        result_ready = 1'b1;
        req0 = 1'b1; offset0 = 4'h3; req1 = 1'b1; offset1 = 4'h8;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("rr%0d_ack0", k), ack0, (k % 2) == 0);
            chk($sformatf("rr%0d_ack1", k), ack1, (k % 2) == 1);
            chk($sformatf("rr%0d_valid_low", k), result_valid, 0);
            step();
            chk($sformatf("rr%0d_valid", k), result_valid, 1);
            chk($sformatf("rr%0d_result", k), result, (k % 2) ? 16'hFFF8 : 16'h0003);
            chk($sformatf("rr%0d_id", k), result_id, k % 2);
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
        chk("rr_end_valid", result_valid, 0);

        // Backpressure with port 1 waiting.
        result_ready = 1'b0;
        req0 = 1'b1; offset0 = 4'h5;
        step();
        chk("bp_ack0", ack0, 1);
        req0 = 1'b0; req1 = 1'b1; offset1 = 4'b1010;
        step();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d_valid", k), result_valid, 1);
            chk($sformatf("bp%0d_result", k), result, 16'h0005);
            chk($sformatf("bp%0d_ack1", k), ack1, 0);
            step();
        end
        result_ready = 1'b1;
        step();
        chk("bp_ready_ack1", ack1, 1);
        chk("bp_ready_valid", result_valid, 0);
        req1 = 1'b0;
        step();
        chk("bp_second_valid", result_valid, 1);
        chk("bp_second_result", result, 16'hFFFA);
        chk("bp_second_id", result_id, 1);
        step();
        chk("bp_second_drop", result_valid, 0);

        // Reset while a result is being held.
        result_ready = 1'b0;
        req0 = 1'b1; offset0 = 4'h5;
        step();
        req0 = 1'b0;
        step();
        chk("rst_pre_valid", result_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_valid", result_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_acks", {ack0, ack1}, 0);
        req0 = 1'b1; req1 = 1'b1; offset0 = 4'h1; offset1 = 4'h2;
        step();
        reset = 1'b0;
        step();
        chk("rst_tie_ack0", ack0, 1);
        chk("rst_tie_ack1", ack1, 0);

`ifdef OFFSET_ARB_ZEXT_EN
        apply_reset();
        result_ready = 1'b1;
        zext0 = 1'b1; req0 = 1'b1; offset0 = 4'b1010;
        step();
        req0 = 1'b0;
        step();
        chk("zext_on_result", result, 16'h000A);
        step();
        zext0 = 1'b0; req0 = 1'b1;
        step();
        req0 = 1'b0;
        step();
        chk("zext_off_result", result, 16'hFFFA);
        step();
`endif

        // Random traffic against a transaction-level scoreboard.
        apply_reset();
        inflight = 0; exp_valid = 0; exp_id = 0; last_m = 1; exp_res = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            d_r0 = req0; d_r1 = req1; d_o0 = offset0; d_o1 = offset1;
            d_z0 = zext0; d_z1 = zext1; d_rdy = result_ready;
            step();
            e_a0 = 0; e_a1 = 0;
            if (!inflight || (exp_valid && d_rdy)) begin
                if (exp_valid && d_rdy) begin
                    inflight = 0; exp_valid = 0;
                end
                if (d_r0 || d_r1) begin
                    w = (d_r0 && d_r1) ? !last_m : d_r1;
                    if (w) e_a1 = 1; else e_a0 = 1;
                    inflight = 1; exp_valid = 0; exp_id = w; last_m = w;
                    exp_res = w ? ext_ref(d_o1, d_z1) : ext_ref(d_o0, d_z0);
                end
            end else if (!exp_valid) begin
                exp_valid = 1;
            end
            chk("rnd_ack0", ack0, e_a0);
            chk("rnd_ack1", ack1, e_a1);
            chk("rnd_valid", result_valid, exp_valid);
            if (exp_valid) begin
                chk("rnd_result", result, exp_res);
                chk("rnd_id", result_id, exp_id);
            end
            if (ack0) begin
                req0 = 1'($urandom_range(0, 1));
                offset0 = 4'($urandom);
`ifdef OFFSET_ARB_ZEXT_EN
                zext0 = 1'($urandom);
`endif
            end else if (!req0 && $urandom_range(0, 3) == 0) begin
                req0 = 1'b1; offset0 = 4'($urandom);
`ifdef OFFSET_ARB_ZEXT_EN
                zext0 = 1'($urandom);
`endif
            end else if (req0 && $urandom_range(0, 15) == 0) begin
                req0 = 1'b0;
            end
            if (ack1) begin
                req1 = 1'($urandom_range(0, 1));
                offset1 = 4'($urandom);
`ifdef OFFSET_ARB_ZEXT_EN
                zext1 = 1'($urandom);
`endif
            end else if (!req1 && $urandom_range(0, 3) == 0) begin
                req1 = 1'b1; offset1 = 4'($urandom);
`ifdef OFFSET_ARB_ZEXT_EN
                zext1 = 1'($urandom);
`endif
            end else if (req1 && $urandom_range(0, 15) == 0) begin
                req1 = 1'b0;
            end
            result_ready = ($urandom_range(0, 2) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/offset_extend_arbiter.md
# offset_extend_arbiter

Shares the single offset sign-extension datapath (IN_WIDTH-bit offset to OUT_WIDTH-bit operand) between two requesters: port 0 (load/store address offset) and port 1 (branch offset). It arbitrates round-robin, latches the granted offset, and produces a registered extended result. The result is held under a valid/ready handshake toward the execute stage. It sits between decode and the ALU operand mux and is the only path into the extender.

## Interface
- IN_WIDTH, 4, width of the raw offset field
- OUT_WIDTH, 16, width of the extended operand; must be greater than or equal to IN_WIDTH

Ports:
- clock  in  1  single clock, rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- req0  in  1  requester 0 wants an extension
- offset0  in  IN_WIDTH  requester 0 raw offset
- ack0  out  1  one-cycle pulse: requester 0 granted, offset0 captured
- req1  in  1  requester 1 wants an extension
- offset1  in  IN_WIDTH  requester 1 raw offset
- ack1  out  1  one-cycle pulse: requester 1 granted, offset1 captured
- result  out  OUT_WIDTH  extended offset
- result_id  out  1  which requester `result` belongs to
- result_valid  out  1  `result` and `result_id` are valid
- result_ready  in  1  consumer accepts `result`
- zext0, zext1  in  1  present only with OFFSET_ARB_ZEXT_EN; per-request zero-extend select

## Operation
The controller is a state machine with states IDLE, EXT and DONE. The reset state is IDLE.

- IDLE: if req0 or req1 is set at a rising edge, grant one requester.
  - On the grant edge: capture that requester's offset (and zext) into op_reg, set sel_reg, pulse the matching ack, update last_grant, and go to EXT.
  - If neither request is set, stay in IDLE.
- EXT: on the next edge, register `result` = op_reg extended to OUT_WIDTH.
  - Bits [IN_WIDTH-1:0] are copied from op_reg.
  - Upper bits are op_reg[IN_WIDTH-1], or 0 when zero-extend is selected.
  - `result_id` = sel_reg, `result_valid` goes to 1, state goes to DONE.
  - EXT ignores all requests.
- DONE: `result`, `result_id` and `result_valid` are held stable while result_ready = 0.
  - On an edge with result_ready = 1 and a request pending: perform a grant exactly as in IDLE, clear result_valid, go to EXT.
  - On an edge with result_ready = 1 and no request pending: clear result_valid, go to IDLE.
- Arbitration:
  - Only one request set: that requester wins.
  - Both set: the requester that is not last_grant wins.
  - last_grant resets to 1, so port 0 wins the first tie.
- Requester rules:
  - Hold req and offset stable until ack is seen.
  - Deassert req in the cycle after ack unless another extension is wanted.
  - A req dropped before its grant edge is simply never granted; there is no error.
- At most one of ack0 and ack1 is set in any cycle. Exactly one transaction is in flight at a time.

## Timing
- Reset values: `result` = 0, `result_id` = 0, `result_valid` = 0, ack0 = 0, ack1 = 0, state = IDLE, last_grant = 1, op_reg = 0.
- From IDLE:
  - Request sampled at edge E.
  - ack is high from E to E+1.
  - result_valid is high after E+1.
- Latency from request to valid is 2 cycles. Best-case throughput, with result_ready tied to 1 and requests pending, is one result per 2 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset asserted mid-transaction (EXT or DONE): the in-flight result is discarded and no ack is reissued. Requesters re-request after reset.
- result_ready while result_valid = 0 is ignored.

## Configuration
- OFFSET_ARB_ZEXT_EN defined:
  - The zext0 and zext1 ports exist.
  - The zext value is captured with the offset at grant.
  - When captured zext = 1, the upper bits are zero-filled.
- Not defined:
  - The zext ports are absent.
  - The upper bits are always sign-filled from op_reg[IN_WIDTH-1].

## Test plan
- Single request: req0 = 1 with offset0 = 4'b0101 and result_ready = 1.
  - Required: ack0 pulses one cycle after the request.
  - Required: result = 16'h0005, result_id = 0, result_valid one cycle later for exactly one cycle.
- Negative offset: req1 = 1 with offset1 = 4'b1010.
  - Required: result = 16'hFFFA, result_id = 1.
- Tie and round-robin: req0 and req1 both held high with offsets 4'h3 and 4'h8, requesters re-asserting after each ack.
  - Required: grants alternate 0,1,0,1 starting with port 0.
  - Required: results are 16'h0003, 16'hFFF8, … each 2 cycles apart.
- Backpressure: result_ready held at 0 for 5 cycles with req1 pending.
  - Required: result and result_valid stay stable and ack1 does not pulse.
  - Required: on the ready edge, ack1 pulses and valid drops for one cycle.
- Reset in DONE with result_valid = 1:
  - Required: result_valid = 0, result = 0 and both acks 0 immediately.
  - Required: after release, req0 = 1 wins the tie against req1 = 1.
- With OFFSET_ARB_ZEXT_EN: req0 with offset0 = 4'b1010 and zext0 = 1.
  - Required: result = 16'h000A.
  - Required: the same offset with zext0 = 0 gives 16'hFFFA.
